// File: rtl/decode_stage_p_if.sv
// Bundle of the decode stage's instruction, write-back and output handshake signals.
// The slave modport is the stage itself; master is the upstream/downstream environment.
interface decode_stage_p_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int OP_W   = 5,
  parameter int IMM_W  = 5,
  parameter int ADDR_W = 16
);
  localparam int IR_W = OP_W + 2*REG_AW + IMM_W;

  logic              in_valid;
  logic              in_ready;
  logic [IR_W-1:0]   ir;
  logic              flush;
  logic              wb_en;
  logic [REG_AW-1:0] wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   op_out;
  logic [REG_AW-1:0] dst_out;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [DATA_W-1:0] X;
  logic [ADDR_W-1:0] Addr;

  modport slave (
    input  in_valid, ir, flush, wb_en, wb_idx, wb_data, out_ready,
    output in_ready, out_valid, op_out, dst_out, valA, valB, X, Addr
  );

  modport master (
    output in_valid, ir, flush, wb_en, wb_idx, wb_data, out_ready,
    input  in_ready, out_valid, op_out, dst_out, valA, valB, X, Addr
  );
endinterface

// File: rtl/decode_stage_p.sv
// Pipelined decode stage: field split, register read with write-back bypass,
// immediate/address formation, one registered output slot and a load-use scoreboard.
module decode_stage_p #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int OP_W   = 5,
  parameter int IMM_W  = 5,
  parameter int ADDR_W = 16,
  parameter logic [OP_W-1:0] LOAD_OP = 5'b01000
) (
  input  logic               T0,
  input  logic               rst,
  decode_stage_p_if.slave    bus
);
  localparam int NREG = 1 << REG_AW;

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic [IMM_W-1:0]  imm;

  assign {op, ra, rb, imm} = bus.ir;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;

  logic              byp_a, byp_b;
  logic [DATA_W-1:0] src_a, src_b;
  logic              hazard, in_ready, accept;

  logic              out_valid_q;
  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] dst_q;
  logic [DATA_W-1:0] val_a_q, val_b_q, x_q;
  logic [ADDR_W-1:0] addr_q;

  // A write-back landing this cycle both forwards its data and releases the busy bit.
  assign byp_a  = bus.wb_en && (bus.wb_idx == ra);
  assign byp_b  = bus.wb_en && (bus.wb_idx == rb);
  assign src_a  = byp_a ? bus.wb_data : regs_q[ra];
  assign src_b  = byp_b ? bus.wb_data : regs_q[rb];
  assign hazard = (busy_q[ra] && !byp_a) || (busy_q[rb] && !byp_b);

  assign in_ready = !rst && !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
      always_ff @(posedge T0) begin
        if (rst) begin
          regs_q[gi] <= '0;
        end else if (bus.wb_en && (bus.wb_idx == REG_AW'(gi))) begin
          regs_q[gi] <= bus.wb_data;
        end
      end
    end
  endgenerate

  // Set is applied after clear so a load issuing to a register being written back stays busy.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_en) busy_d[bus.wb_idx] = 1'b0;
    if (accept && (op == LOAD_OP)) busy_d[ra] = 1'b1;
  end

  always_ff @(posedge T0) begin
    if (rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      dst_q       <= '0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      x_q         <= '0;
      addr_q      <= '0;
    end else begin
      busy_q <= busy_d;
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        op_q        <= op;
        dst_q       <= ra;
        val_a_q     <= src_a;
        val_b_q     <= src_b;
        x_q         <= DATA_W'($signed(imm));
        addr_q      <= ADDR_W'({rb, imm});
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.op_out    = op_q;
  assign bus.dst_out   = dst_q;
  assign bus.valA      = val_a_q;
  assign bus.valB      = val_b_q;
  assign bus.X         = x_q;
  assign bus.Addr      = addr_q;
endmodule

// File: tb/tb_decode_stage_p.sv
// Scenario bench for decode_stage_p: expected decode results are queued at accept
// and popped when the output stage presents them.
module tb_decode_stage_p;
  logic T0 = 1'b0;
  logic rst;
  always #5 T0 = ~T0;

  decode_stage_p_if bus();
  decode_stage_p dut (.T0(T0), .rst(rst), .bus(bus));

  typedef logic [47:0] exp_t;  // {op, dst, valA, valB, X, Addr}

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t exp_v;
  logic [7:0] m_regs [8];
  logic [7:0] m_busy;
  logic [47:0] got;

  assign got = {bus.op_out, bus.dst_out, bus.valA, bus.valB, bus.X, bus.Addr};

  function automatic exp_t model(logic [15:0] ir, logic wbe, logic [2:0] wbi, logic [7:0] wbd);
    logic [4:0] op;
    logic [2:0] ra, rb;
    logic [4:0] imm;
    logic [7:0] a, b;
    op  = ir[15:11];
    ra  = ir[10:8];
    rb  = ir[7:5];
    imm = ir[4:0];
    a = (wbe && wbi == ra) ? wbd : m_regs[ra];
    b = (wbe && wbi == rb) ? wbd : m_regs[rb];
    return {op, ra, a, b, {{3{imm[4]}}, imm}, {8'h00, rb, imm}};
  endfunction

  task automatic idle();
    bus.in_valid = 1'b0; bus.ir = '0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_idx = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_busy = 8'h00;
    sb_q.delete();
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [7:0] data);
    bus.wb_en = 1'b1; bus.wb_idx = idx; bus.wb_data = data;
    @(posedge T0);
    m_regs[idx] = data; m_busy[idx] = 1'b0;
    #1 bus.wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    repeat (2) @(posedge T0);
    @(negedge T0);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    @(posedge T0); #1 rst = 1'b0;
    model_clear();
    @(negedge T0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (got !== 48'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, 48'h0); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge T0); #1;
  endtask

  task automatic test_basic_add();
    wb_write(3'd0, 8'h12);
    wb_write(3'd1, 8'h34);
    bus.ir = 16'b00000_000_001_00000; bus.in_valid = 1'b1;
    @(negedge T0);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready got=%b exp=1", bus.in_ready); end
    if (bus.in_ready) sb_q.push_back(model(bus.ir, 1'b0, 3'd0, 8'h00));
    @(posedge T0); #1 bus.in_valid = 1'b0;
    @(negedge T0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%b exp=1", bus.out_valid); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    checks++; if (got !== exp_v) begin failures++; $display("FAIL add_sb got=%h exp=%h", got, exp_v); end
    checks++; if (got !== {5'd0, 3'd0, 8'h12, 8'h34, 8'h00, 16'h0020}) begin failures++; $display("FAIL add_const got=%h exp=%h", got, {5'd0, 3'd0, 8'h12, 8'h34, 8'h00, 16'h0020}); end
    @(posedge T0); #1;
    @(negedge T0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", bus.out_valid); end
    @(posedge T0); #1;
  endtask

  task automatic test_sign_ext_bypass();
    bus.ir = 16'b00001_010_011_10110; bus.in_valid = 1'b1;
    bus.wb_en = 1'b1; bus.wb_idx = 3'd2; bus.wb_data = 8'h5A;
    @(negedge T0);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL sext_in_ready got=%b exp=1", bus.in_ready); end
    if (bus.in_ready) sb_q.push_back(model(bus.ir, 1'b1, 3'd2, 8'h5A));
    @(posedge T0);
    m_regs[2] = 8'h5A;
    #1 bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    @(negedge T0);
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    checks++; if (got !== exp_v || bus.out_valid !== 1'b1) begin failures++; $display("FAIL sext_sb got=%h v=%b exp=%h", got, bus.out_valid, exp_v); end
    checks++; if (got !== {5'd1, 3'd2, 8'h5A, 8'h00, 8'hF6, 16'h0076}) begin failures++; $display("FAIL sext_const got=%h exp=%h", got, {5'd1, 3'd2, 8'h5A, 8'h00, 8'hF6, 16'h0076}); end
    @(posedge T0); #1;
  endtask

  task automatic test_load_use();
    bus.ir = 16'b01000_011_000_00000; bus.in_valid = 1'b1;
    @(negedge T0);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL load_in_ready got=%b exp=1", bus.in_ready); end
    if (bus.in_ready) sb_q.push_back(model(bus.ir, 1'b0, 3'd0, 8'h00));
    @(posedge T0);
    m_busy[3] = 1'b1;
    #1 bus.ir = 16'b00000_001_011_00000;
    for (int c = 0; c < 4; c++) begin
      @(negedge T0);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
      if (c == 0) begin
        exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        checks++; if (got !== exp_v || bus.out_valid !== 1'b1) begin failures++; $display("FAIL load_sb got=%h v=%b exp=%h", got, bus.out_valid, exp_v); end
      end
      @(posedge T0); #1;
    end
    bus.wb_en = 1'b1; bus.wb_idx = 3'd3; bus.wb_data = 8'h77;
    @(negedge T0);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL wake_in_ready got=%b exp=1", bus.in_ready); end
    if (bus.in_ready) sb_q.push_back(model(bus.ir, 1'b1, 3'd3, 8'h77));
    @(posedge T0);
    m_regs[3] = 8'h77; m_busy[3] = 1'b0;
    #1 bus.wb_en = 1'b0; bus.in_valid = 1'b0; bus.ir = 16'b00000_011_011_00000;
    @(negedge T0);
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    checks++; if (got !== exp_v || bus.out_valid !== 1'b1) begin failures++; $display("FAIL wake_sb got=%h v=%b exp=%h", got, bus.out_valid, exp_v); end
    checks++; if (got[31:24] !== 8'h77) begin failures++; $display("FAIL wake_valB got=%h exp=77", got[31:24]); end
    // in_ready is probed with in_valid low: it must already see busy[3] released.
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL busy_cleared got=%b exp=1", bus.in_ready); end
    @(posedge T0); #1;
  endtask

  task automatic test_flush_and_reset();
    bus.ir = 16'b01000_101_000_00000; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    bus.wb_en = 1'b1; bus.wb_idx = 3'd5; bus.wb_data = 8'h99;
    @(negedge T0);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL setwin_in_ready got=%b exp=1", bus.in_ready); end
    if (bus.in_ready) sb_q.push_back(model(bus.ir, 1'b1, 3'd5, 8'h99));
    @(posedge T0);
    m_regs[5] = 8'h99; m_busy[5] = 1'b1;
    #1 bus.in_valid = 1'b0; bus.wb_en = 1'b0; bus.flush = 1'b1;
    @(negedge T0);
    exp_v = (sb_q.size() > 0) ? sb_q[0] : '1;
    checks++; if (got !== exp_v || bus.out_valid !== 1'b1) begin failures++; $display("FAIL preflush_sb got=%h v=%b exp=%h", got, bus.out_valid, exp_v); end
    @(posedge T0);
    // The flushed load never reaches the consumer.
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    #1 bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.ir = 16'b00000_000_101_00000; bus.in_valid = 1'b1;
    @(negedge T0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_kill got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL busy_kept_after_flush got=%b exp=0", bus.in_ready); end
    @(posedge T0); #1 rst = 1'b1;
    @(negedge T0);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL in_ready_in_reset got=%b exp=0", bus.in_ready); end
    @(posedge T0); #1 rst = 1'b0;
    model_clear();
    @(negedge T0);
    checks++; if (got !== 48'h0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL midstall_reset_outputs got=%h v=%b exp=0", got, bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL in_ready_after_reset got=%b exp=1", bus.in_ready); end
    if (bus.in_ready) sb_q.push_back(model(bus.ir, 1'b0, 3'd0, 8'h00));
    @(posedge T0); #1 bus.in_valid = 1'b0;
    @(negedge T0);
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    checks++; if (got !== exp_v || bus.out_valid !== 1'b1) begin failures++; $display("FAIL regs_cleared_sb got=%h v=%b exp=%h", got, bus.out_valid, exp_v); end
    @(posedge T0); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] irs [8];
    int idx = 0;
    int popped = 0;
    int cyc = 0;
    for (int i = 0; i < 8; i++) wb_write(3'(i), 8'(8'h10 * i + 3));
    for (int i = 0; i < 8; i++) irs[i] = {5'(i), 3'(i), 3'(7 - i), 5'(i * 3 + 1)};
    while (popped < 8 && cyc < 40) begin
      bus.in_valid  = (idx < 8);
      bus.ir        = (idx < 8) ? irs[idx] : 16'h0;
      bus.out_ready = !(cyc >= 1 && cyc <= 3);
      @(negedge T0);
      if (cyc >= 1 && cyc <= 3) begin
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, bus.in_ready); end
      end else if (idx < 8) begin
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", cyc, bus.in_ready); end
      end
      if (bus.out_valid) begin
        exp_v = (sb_q.size() > 0) ? sb_q[0] : '1;
        checks++; if (got !== exp_v) begin failures++; $display("FAIL b2b_sb cyc=%0d got=%h exp=%h", cyc, got, exp_v); end
        if (bus.out_ready) begin
          if (sb_q.size() > 0) void'(sb_q.pop_front());
          popped++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(model(irs[idx], 1'b0, 3'd0, 8'h00));
        idx++;
      end
      @(posedge T0); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (popped !== 8 || idx !== 8 || sb_q.size() !== 0) begin failures++; $display("FAIL b2b_count popped=%0d issued=%0d left=%0d exp=8/8/0", popped, idx, sb_q.size()); end
    @(negedge T0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_dup got=%b exp=0", bus.out_valid); end
    @(posedge T0); #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_clear();
    test_reset();
    test_basic_add();
    test_sign_ext_bypass();
    test_load_use();
    test_flush_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
